keypad_scanner: RTL and testbench

Matrix-scan front end for the smart-lock keypad. It drives the rows of a 4x3 key matrix, samples the columns and debounces the result. It presents one debounced level per key to the lock FSM stage, which performs its own edge detection on each line. The '*' key produces the clear/reset level consumed downstream as the lock's reset input.

---
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x3 keypad matrix scanner: row sequencer, column capture, frame classification and debounce.
// Optional KEYPAD_GHOST_REJECT_EN: committed multi-key frames drive all outputs low.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 8,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] key,
  output logic       key_clr,
  output logic       key_hash
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] CLS_NONE   = 2'd0;
  localparam logic [1:0] CLS_SINGLE = 2'd1;
  localparam logic [1:0] CLS_MULTI  = 2'd2;

  logic [2:0]       col_meta;
  logic [2:0]       col_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [11:0]      frame_map;
  logic [CNT_W-1:0] stable_cnt;
  logic [1:0]       prev_kind;
  logic [3:0]       prev_idx;

  logic             win_last_c;
  logic             frame_end_c;
  logic [1:0]       row_nxt_c;
  logic [11:0]      row_hits_c;
  logic [11:0]      frame_next_c;
  logic [3:0]       nbits_c;
  logic [3:0]       cls_idx_c;
  logic [1:0]       cls_kind_c;
  logic             same_c;
  logic [CNT_W-1:0] cnt_next_c;
  logic             commit_c;
  logic             decode_en_c;
  logic [9:0]       key_d_c;
  logic             clr_d_c;
  logic             hash_d_c;

  assign win_last_c  = (div == DIV_LAST);
  assign frame_end_c = win_last_c && (row_idx == 2'd3);
  assign row_nxt_c   = row_idx + 2'd1;

  // Accumulate the current row's pressed columns into the frame map
  always_comb begin
    row_hits_c = '0;
    case (row_idx)
      2'd0:    row_hits_c[2:0]  = ~col_sync;
      2'd1:    row_hits_c[5:3]  = ~col_sync;
      2'd2:    row_hits_c[8:6]  = ~col_sync;
      default: row_hits_c[11:9] = ~col_sync;
    endcase
    frame_next_c = frame_map | (win_last_c ? row_hits_c : 12'd0);
  end

  // Classify the frame; scanning downward leaves the lowest set index
  always_comb begin
    nbits_c   = '0;
    cls_idx_c = '0;
    for (int i = 11; i >= 0; i--) begin
      if (frame_next_c[i]) begin
        cls_idx_c = 4'(i);
        nbits_c   = nbits_c + 4'd1;
      end
    end
    if (nbits_c == 4'd0)      cls_kind_c = CLS_NONE;
    else if (nbits_c == 4'd1) cls_kind_c = CLS_SINGLE;
    else                      cls_kind_c = CLS_MULTI;
  end

  // Debounce: only SINGLE carries its key identity into the comparison
  always_comb begin
    same_c = (cls_kind_c == prev_kind) &&
             ((cls_kind_c != CLS_SINGLE) || (cls_idx_c == prev_idx));
    if (!same_c)                  cnt_next_c = CNT_ONE;
    else if (stable_cnt >= CNT_SAT) cnt_next_c = CNT_SAT;
    else                          cnt_next_c = CNT_W'(stable_cnt + CNT_ONE);
    commit_c = frame_end_c && (cnt_next_c == CNT_SAT);
  end

  always_comb begin
`ifdef KEYPAD_GHOST_REJECT_EN
    decode_en_c = (cls_kind_c == CLS_SINGLE);
`else
    decode_en_c = (cls_kind_c != CLS_NONE);
`endif
    key_d_c  = '0;
    clr_d_c  = 1'b0;
    hash_d_c = 1'b0;
    if (decode_en_c) begin
      // Index 0..8 are digits 1..9, 9 is '*', 10 is '0', 11 is '#'
      for (int d = 0; d < 9; d++) begin
        if (cls_idx_c == 4'(d)) key_d_c[d+1] = 1'b1;
      end
      if (cls_idx_c == 4'd9)  clr_d_c    = 1'b1;
      if (cls_idx_c == 4'd10) key_d_c[0] = 1'b1;
      if (cls_idx_c == 4'd11) hash_d_c   = 1'b1;
    end
  end

  // Synchronizer, row sequencer and frame map
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta  <= 3'b111;
      col_sync  <= 3'b111;
      div       <= '0;
      row_idx   <= '0;
      row_n     <= 4'b1110;
      frame_map <= '0;
    end else begin
      col_meta  <= col_n;
      col_sync  <= col_meta;
      frame_map <= frame_end_c ? 12'd0 : frame_next_c;
      if (win_last_c) begin
        div     <= '0;
        row_idx <= row_nxt_c;
        row_n   <= ~(4'b0001 << row_nxt_c);
      end else begin
        div <= DIV_W'(div + 1'b1);
      end
    end
  end

  // Stable counter and committed outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= '0;
      prev_kind  <= CLS_NONE;
      prev_idx   <= '0;
      key        <= '0;
      key_clr    <= 1'b0;
      key_hash   <= 1'b0;
    end else if (frame_end_c) begin
      stable_cnt <= cnt_next_c;
      prev_kind  <= cls_kind_c;
      prev_idx   <= cls_idx_c;
      if (commit_c) begin
        key      <= key_d_c;
        key_clr  <= clr_d_c;
        key_hash <= hash_d_c;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized self-checking bench for keypad_scanner against a frame-level key-set model.
// Build with +define+KEYPAD_GHOST_REJECT_EN to match a ghost-rejecting DUT.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned F  = 4 * SD;
  localparam int unsigned LAT = (DB + 1) * F + 3;

  logic        clk;
  logic        reset_n;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [9:0]  key;
  logic        key_clr;
  logic        key_hash;
  logic [11:0] held;
  logic [11:0] obs;

  int total = 0;
  int bad   = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .col_n(col_n), .row_n(row_n),
    .key(key), .key_clr(key_clr), .key_hash(key_hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {key_hash, key_clr, key};

  // Passive matrix: a held key shorts its driven row onto its column
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_n[r] && held[r*3+c]) col_n[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Key label per matrix position (row*3+col); -1 is '*', -2 is '#'
  function automatic logic [11:0] label_bit(input int pos);
    int lbl [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, 0, -2};
    logic [11:0] v;
    v = '0;
    if (lbl[pos] == -1)      v[10] = 1'b1;
    else if (lbl[pos] == -2) v[11] = 1'b1;
    else                     v[lbl[pos]] = 1'b1;
    return v;
  endfunction

  function automatic logic [11:0] model_out(input logic [11:0] s);
    int n;
    n = $countones(s);
    if (n == 0) return '0;
`ifdef KEYPAD_GHOST_REJECT_EN
    if (n > 1) return '0;
`endif
    for (int i = 0; i < 12; i++)
      if (s[i]) return label_bit(i);
    return '0;
  endfunction

  task automatic wait_out(input string tag, input logic [11:0] exp, input int max_cyc,
                          output int cyc);
    cyc = 0;
    while (obs !== exp && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(obs), 32'(exp));
  endtask

  always @(negedge clk)
    if (reset_n) chk("onehot", 32'($countones(obs) <= 1), 32'd1);

  initial begin
    int cyc;
    logic [11:0] prev_set, new_set, old_exp, new_exp;
    int n;

    reset_n = 1'b0;
    held    = '0;
    repeat (2) @(negedge clk);
    chk("rst_row", 32'(row_n), 32'hE);
    chk("rst_out", 32'(obs), 32'h0);

    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("row_seq", 32'(row_n), 32'(~(4'b0001 << (((i + 1) / 4) % 4)) & 4'hF));
    end

    // Clean press of '2' from a frame boundary
    held = 12'b0000_0000_0010;
    wait_out("press2", model_out(held), LAT, cyc);
    chk("press2_val", 32'(key), 32'h004);
    repeat (20) @(negedge clk);
    chk("press2_hold", 32'(obs), 32'(model_out(held)));
    held = '0;
    wait_out("rel2", 12'h000, LAT, cyc);

    // Bounce on '5': never three equal frames in a row
    for (int i = 0; i < 200; i++) begin
      if (i % 6 == 0) held[4] = ~held[4];
      @(negedge clk);
      chk("bounce", 32'(obs), 32'h0);
    end
    held = '0;
    repeat (5 * F) @(negedge clk);
    chk("bounce_end", 32'(obs), 32'h0);

    held = 12'b0010_0000_0000;
    repeat (100) @(negedge clk);
    chk("clr", 32'(obs), 32'h400);
    held = '0;
    wait_out("clr_rel", 12'h000, LAT, cyc);

    held = 12'b1000_0000_0000;
    repeat (100) @(negedge clk);
    chk("hash", 32'(obs), 32'h800);
    held = '0;
    wait_out("hash_rel", 12'h000, LAT, cyc);

    // '1' and '9' together
    held = 12'b0001_0000_0001;
    repeat (LAT) @(negedge clk);
`ifdef KEYPAD_GHOST_REJECT_EN
    chk("multi", 32'(obs), 32'h000);
`else
    chk("multi", 32'(obs), 32'h002);
`endif
    held = '0;
    wait_out("multi_rel", 12'h000, LAT, cyc);

    // Mid-press reset on '7'
    held = 12'b0000_0100_0000;
    wait_out("press7", 12'h080, LAT, cyc);
    reset_n = 1'b0;
    #1;
    chk("rst_async", 32'(obs), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_out("press7_again", 12'h080, LAT, cyc);
    chk("press7_min", 32'(cyc >= int'(3 * F)), 32'd1);
    held = '0;
    wait_out("rel7", 12'h000, LAT, cyc);

    // Random key sets applied at random phases
    prev_set = '0;
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(0, 2);
      new_set = '0;
      while ($countones(new_set) < n) new_set[$urandom_range(0, 11)] = 1'b1;
      old_exp = model_out(prev_set);
      new_exp = model_out(new_set);
      repeat ($urandom_range(0, 15)) @(negedge clk);
      held = new_set;
      repeat (30) @(negedge clk);
`ifdef KEYPAD_GHOST_REJECT_EN
      chk("rnd_early", 32'(obs), 32'(old_exp));
`else
      // Consecutive multi frames stay stable, so they may re-commit at once
      if ($countones(prev_set) <= 1) chk("rnd_early", 32'(obs), 32'(old_exp));
`endif
      repeat (LAT - 30 + 3) @(negedge clk);
      chk("rnd_settled", 32'(obs), 32'(new_exp));
      prev_set = new_set;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
